pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_2000, PC value loaded on reset.
REQ-003 Parameter TRAP_PC, default 32'h0000_1000, trap/misalign handler address.
REQ-004 Parameter INC, default 4, sequential PC increment in bytes.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  hold PC; redirects received meanwhile are buffered.
REQ-008 pc_sel  input  1  take redirect to alu_out this cycle.
REQ-009 alu_out  input  XLEN  redirect target from execute stage.
REQ-010 trap  input  1  force next PC to TRAP_PC.
REQ-011 pc_out  output  XLEN  current fetch PC (registered).
REQ-012 pc_prev  output  XLEN  PC value held before the most recent update.
REQ-013 redirect_pending  output  1  a buffered redirect is waiting.
REQ-014 misalign  output  1  one-cycle pulse: a redirect target was misaligned.
REQ-015 epc  output  XLEN  captured faulting target or trapping PC.

Function
REQ-016 Next-PC priority per posedge SHALL be: trap > misaligned redirect > pc_sel (stall low) > pending (stall low) > stall hold > pc_out+INC.
REQ-017 trap=1 SHALL load TRAP_PC, load epc<=pc_out, clear pending, regardless of stall.
REQ-018 A redirect (pc_sel=1) with alu_out[1:0]!=0 SHALL load TRAP_PC, load epc<=alu_out, pulse misalign for one cycle, clear pending, regardless of stall.
REQ-019 Aligned pc_sel=1 with stall=0 SHALL load pc_out<=alu_out and clear pending.
REQ-020 Aligned pc_sel=1 with stall=1 SHALL hold pc_out, latch alu_out into the pending register, set redirect_pending; a newer aligned redirect overwrites the older.
REQ-021 stall=0, pc_sel=0, redirect_pending=1 SHALL load pc_out<=pending target and clear redirect_pending in that cycle.
REQ-022 stall=1 with no trap/misalign/redirect SHALL hold pc_out, pc_prev, pending unchanged.
REQ-023 Otherwise pc_out<=pc_out+INC, modulo 2^XLEN (wrap from all-ones-minus-3 to 0, no flag).
REQ-024 pc_prev SHALL load the old pc_out whenever pc_out changes value source (any non-hold update) and hold otherwise.
REQ-025 misalign SHALL be 0 in every cycle not described in REQ-018.
REQ-026 epc SHALL change only on REQ-017/REQ-018 events.
REQ-027 Update latency: pc_out reflects an input decision one posedge after it is sampled; no combinational path from inputs to outputs.

Reset
REQ-028 reset_n=0 SHALL asynchronously force pc_out=RESET_PC, pc_prev=RESET_PC, redirect_pending=0, pending target=0, misalign=0, epc=0.
REQ-029 Reset asserted mid-stall with a buffered redirect SHALL discard the redirect.
REQ-030 First posedge after reset_n rises with stall=0, pc_sel=0, trap=0 SHALL yield pc_out=RESET_PC+INC.

Verification
REQ-031 Reset release, 3 free cycles -> pc_out 0x2004, 0x2008, 0x200C; pc_prev lags one step.
REQ-032 pc_out=0x2008, pc_sel=1, alu_out=0x3000, stall=0 -> pc_out=0x3000 next edge, then 0x3004.
REQ-033 stall=1 two cycles, pc_sel=1 alu_out=0x4000 in first, 0x5000 in second -> pc_out held, redirect_pending=1; stall drops -> pc_out=0x5000, pending=0.
REQ-034 pc_sel=1 alu_out=0x3002 -> pc_out=0x1000, misalign=1 for exactly one cycle, epc=0x3002.
REQ-035 trap=1 with stall=1 and pending redirect at pc_out=0x2010 -> pc_out=0x1000, epc=0x2010, redirect_pending=0.
REQ-036 XLEN=32, pc_sel to 0xFFFF_FFFC then free-run -> pc_out=0x0000_0000; reset_n pulsed low mid-clock -> pc_out=0x2000 immediately, before next edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential increment, execute-stage redirects (buffered while stalled),
// traps and misaligned-target traps. One posedge of latency; stall holds the PC; all outputs registered.
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_1000,
  parameter int              INC      = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic            trap,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_prev,
  output logic            redirect_pending,
  output logic            misalign,
  output logic [XLEN-1:0] epc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_prev;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend_vld;
  logic            r_misalign;
  logic [XLEN-1:0] r_epc;

  logic            w_misalign;
  logic [XLEN-1:0] w_pc_inc;

  assign w_misalign = pc_sel && (alu_out[1:0] != 2'b00);
  assign w_pc_inc   = r_pc + XLEN'(INC);

  // Priority chain: trap > misaligned redirect > redirect > pending > stall hold > increment.
  // Misaligned redirects and traps act even while stalled; the buffered redirect is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_pc_prev  <= RESET_PC;
      r_pend_pc  <= '0;
      r_pend_vld <= 1'b0;
      r_misalign <= 1'b0;
      r_epc      <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (trap) begin
        r_pc       <= TRAP_PC;
        r_pc_prev  <= r_pc;
        r_epc      <= r_pc;
        r_pend_vld <= 1'b0;
      end else if (w_misalign) begin
        r_pc       <= TRAP_PC;
        r_pc_prev  <= r_pc;
        r_epc      <= alu_out;
        r_misalign <= 1'b1;
        r_pend_vld <= 1'b0;
      end else if (pc_sel && !stall) begin
        r_pc       <= alu_out;
        r_pc_prev  <= r_pc;
        r_pend_vld <= 1'b0;
      end else if (pc_sel) begin
        r_pend_pc  <= alu_out;
        r_pend_vld <= 1'b1;
      end else if (r_pend_vld && !stall) begin
        r_pc       <= r_pend_pc;
        r_pc_prev  <= r_pc;
        r_pend_vld <= 1'b0;
      end else if (!stall) begin
        r_pc      <= w_pc_inc;
        r_pc_prev <= r_pc;
      end
    end
  end

  assign pc_out           = r_pc;
  assign pc_prev          = r_pc_prev;
  assign redirect_pending = r_pend_vld;
  assign misalign         = r_misalign;
  assign epc              = r_epc;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with hand-computed expected PC/prev/pending/misalign/epc values.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] alu_out = '0;
  logic        trap = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_prev;
  logic        redirect_pending;
  logic        misalign;
  logic [31:0] epc;

  int n_vec = 0;
  int n_err = 0;

  pc_gen dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .pc_sel           (pc_sel),
    .alu_out          (alu_out),
    .trap             (trap),
    .pc_out           (pc_out),
    .pc_prev          (pc_prev),
    .redirect_pending (redirect_pending),
    .misalign         (misalign),
    .epc              (epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sel, input logic [31:0] tgt, input logic t);
    stall   = s;
    pc_sel  = sel;
    alu_out = tgt;
    trap    = t;
  endtask

  initial begin
    #12;
    chk("rst_pc", pc_out, 32'h2000);
    chk("rst_prev", pc_prev, 32'h2000);
    chk("rst_pend", {31'b0, redirect_pending}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    reset_n = 1'b1;

    // Free run
    step(); chk("free1_pc", pc_out, 32'h2004); chk("free1_prev", pc_prev, 32'h2000);
    step(); chk("free2_pc", pc_out, 32'h2008); chk("free2_prev", pc_prev, 32'h2004);
    step(); chk("free3_pc", pc_out, 32'h200C); chk("free3_prev", pc_prev, 32'h2008);

    // Immediate redirect
    drive(0, 1, 32'h3000, 0);
    step(); chk("redir_pc", pc_out, 32'h3000); chk("redir_prev", pc_prev, 32'h200C);
    drive(0, 0, 0, 0);
    step(); chk("redir_inc", pc_out, 32'h3004);

    // Buffered redirects under stall, newer overwrites older
    drive(1, 1, 32'h4000, 0);
    step(); chk("stall1_pc", pc_out, 32'h3004); chk("stall1_pend", {31'b0, redirect_pending}, 32'd1);
    chk("stall1_prev", pc_prev, 32'h3000);
    drive(1, 1, 32'h5000, 0);
    step(); chk("stall2_pc", pc_out, 32'h3004); chk("stall2_pend", {31'b0, redirect_pending}, 32'd1);
    drive(0, 0, 0, 0);
    step(); chk("pend_pc", pc_out, 32'h5000); chk("pend_clr", {31'b0, redirect_pending}, 32'd0);
    chk("pend_prev", pc_prev, 32'h3004);
    step(); chk("pend_inc", pc_out, 32'h5004);

    // Misaligned redirect
    drive(0, 1, 32'h3002, 0);
    step(); chk("mis_pc", pc_out, 32'h1000); chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_epc", epc, 32'h3002); chk("mis_prev", pc_prev, 32'h5004);
    drive(0, 0, 0, 0);
    step(); chk("mis_drop", {31'b0, misalign}, 32'd0); chk("mis_inc", pc_out, 32'h1004);
    chk("mis_epc_hold", epc, 32'h3002);

    // Plain stall hold
    drive(1, 0, 0, 0);
    step(); chk("hold_pc", pc_out, 32'h1004); chk("hold_prev", pc_prev, 32'h1000);

    // Trap beats a simultaneous misaligned redirect
    drive(0, 1, 32'h7001, 1);
    step(); chk("trapmis_pc", pc_out, 32'h1000); chk("trapmis_epc", epc, 32'h1004);
    chk("trapmis_mis", {31'b0, misalign}, 32'd0);

    // Trap while stalled with a pending redirect
    drive(0, 1, 32'h2010, 0);
    step(); chk("to2010", pc_out, 32'h2010);
    drive(1, 1, 32'h6000, 0);
    step(); chk("tp_pend", {31'b0, redirect_pending}, 32'd1);
    drive(1, 0, 0, 1);
    step(); chk("tp_pc", pc_out, 32'h1000); chk("tp_epc", epc, 32'h2010);
    chk("tp_pend_clr", {31'b0, redirect_pending}, 32'd0); chk("tp_prev", pc_prev, 32'h2010);
    drive(0, 0, 0, 0);
    step(); chk("tp_after", pc_out, 32'h1004);

    // Wrap at top of address space
    drive(0, 1, 32'hFFFF_FFFC, 0);
    step(); chk("wrap_top", pc_out, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    step(); chk("wrap_zero", pc_out, 32'h0000_0000); chk("wrap_prev", pc_prev, 32'hFFFF_FFFC);

    // Async reset mid-stall discards a buffered redirect
    drive(1, 1, 32'h8000, 0);
    step(); chk("ar_pend", {31'b0, redirect_pending}, 32'd1);
    drive(1, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_pc", pc_out, 32'h2000); chk("ar_prev", pc_prev, 32'h2000);
    chk("ar_pend_clr", {31'b0, redirect_pending}, 32'd0); chk("ar_epc", epc, 32'h0);
    #1 reset_n = 1'b1;
    drive(0, 0, 0, 0);
    step(); chk("ar_first", pc_out, 32'h2004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
